// File: rtl/gf2m_pkg.sv
// Shared definitions for the GF(2^M) digit-serial multiplier: digit-count helper,
// FSM state type and default field/digit sizes.
package gf2m_pkg;

  localparam int GF2M_M_DEFAULT = 7;
  localparam int GF2M_D_DEFAULT = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } gf2m_state_t;

  // Number of D-bit digits needed to cover an M-bit operand.
  function automatic int gf2m_num_digits(input int m, input int d);
    return (m + d - 1) / d;
  endfunction

endpackage

// File: rtl/gf2m_digit_step.sv
// One digit of the MSB-first multiply: r*x^D mod f xor a*digit mod f.
// Purely combinational; depth is D reduction stages plus a D-input XOR tree.
module gf2m_digit_step
  import gf2m_pkg::*;
#(
  parameter int M = GF2M_M_DEFAULT,
  parameter int D = GF2M_D_DEFAULT
) (
  input  logic [M-1:0] r,
  input  logic [M-1:0] a,
  input  logic [M-1:0] f,
  input  logic [D-1:0] digit,
  output logic [M-1:0] r_next
);

  // Multiply by x and fold the overflowing x^M term back in via f.
  function automatic logic [M-1:0] mulx(input logic [M-1:0] v, input logic [M-1:0] p);
    return {v[M-2:0], 1'b0} ^ (v[M-1] ? p : '0);
  endfunction

  logic [M-1:0] r_shift;
  logic [M-1:0] a_pow;
  logic [M-1:0] prod;

  always_comb begin
    r_shift = r;
    a_pow   = a;
    prod    = '0;
    for (int i = 0; i < D; i++) begin
      r_shift = mulx(r_shift, f);
    end
    for (int j = 0; j < D; j++) begin
      if (digit[j]) begin
        prod = prod ^ a_pow;
      end
      a_pow = mulx(a_pow, f);
    end
    r_next = r_shift ^ prod;
  end

endmodule

// File: rtl/gf2m_digit_serial_mult.sv
// Digit-serial GF(2^M) multiplier, D bits of b per clock, MSB digit first; N=ceil(M/D) cycle latency.
// Optional GF2M_MAC_EN adds an acc port XORed into the result.
module gf2m_digit_serial_mult
  import gf2m_pkg::*;
#(
  parameter int M = GF2M_M_DEFAULT,
  parameter int D = GF2M_D_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  input  logic [M:0]   f,
`ifdef GF2M_MAC_EN
  input  logic [M-1:0] acc,
`endif
  output logic [M-1:0] c,
  output logic         busy,
  output logic         over
);

  localparam int N  = gf2m_num_digits(M, D);
  localparam int BW = N * D;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  gf2m_state_t   state;
  gf2m_state_t   state_nxt;
  logic          load;
  logic          last;
  logic [CW-1:0] cnt;
  logic [M-1:0]  a_q;
  logic [M-1:0]  f_q;
  logic [BW-1:0] b_sh;
  logic [M-1:0]  r;
  logic [M-1:0]  r_next;
  logic [D-1:0]  digit;
  logic [M-1:0]  result;

  // The leading coefficient of f is always 1 and never looked at.
  logic          f_msb_unused;
  assign f_msb_unused = f[M];

`ifdef GF2M_MAC_EN
  logic [M-1:0]  acc_q;
  assign result = r_next ^ acc_q;
`else
  assign result = r_next;
`endif

  // b is kept left-aligned in a shift register so the current digit is always the top D bits.
  assign digit = b_sh[BW-1 -: D];
  assign busy  = (state == RUN);

  gf2m_digit_step #(
    .M(M),
    .D(D)
  ) u_step (
    .r      (r),
    .a      (a_q),
    .f      (f_q),
    .digit  (digit),
    .r_next (r_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (cnt == '0) begin
          last      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      r    <= '0;
      c    <= '0;
      over <= 1'b0;
      a_q  <= '0;
      f_q  <= '0;
      b_sh <= '0;
`ifdef GF2M_MAC_EN
      acc_q <= '0;
`endif
    end else begin
      over <= 1'b0;
      if (load) begin
        a_q  <= a;
        f_q  <= f[M-1:0];
        b_sh <= BW'(b);
        r    <= '0;
        cnt  <= CW'(N - 1);
`ifdef GF2M_MAC_EN
        acc_q <= acc;
`endif
      end else if (state == RUN) begin
        r    <= r_next;
        b_sh <= b_sh << D;
        cnt  <= cnt - 1'b1;
        if (last) begin
          c    <= result;
          over <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_gf2m_digit_serial_mult.sv
// Bench for gf2m_digit_serial_mult: four instances (M=7, D=2,1,3,7) checked against a
// full-product-then-long-division model; GF2M_MAC_EN adds the accumulate case.
module tb_gf2m_digit_serial_mult;

  localparam int NI = 4;

  logic       clk;
  logic       rst;
  logic [7:0] fpoly;
  logic [6:0] acc_val;
  logic       dut_start [NI];
  logic [6:0] dut_a     [NI];
  logic [6:0] dut_b     [NI];
  logic [6:0] dut_c     [NI];
  logic       dut_busy  [NI];
  logic       dut_over  [NI];

  int total = 0;
  int bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int DV = (g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 3 : 7;
    gf2m_digit_serial_mult #(
      .M(7),
      .D(DV)
    ) u_dut (
      .clk   (clk),
      .rst   (rst),
      .start (dut_start[g]),
      .a     (dut_a[g]),
      .b     (dut_b[g]),
      .f     (fpoly),
`ifdef GF2M_MAC_EN
      .acc   (acc_val),
`endif
      .c     (dut_c[g]),
      .busy  (dut_busy[g]),
      .over  (dut_over[g])
    );
  end

  function automatic int nd(input int g);
    case (g)
      0:       return 4;
      1:       return 7;
      2:       return 3;
      default: return 1;
    endcase
  endfunction

  // Reference: full 13-bit carry-less product, then long division by x^7 + f[6:0].
  function automatic logic [6:0] ref_mul(input logic [6:0] x, input logic [6:0] y, input logic [7:0] fp);
    logic [13:0] p;
    logic [13:0] fw;
    p  = '0;
    fw = {6'b0, 1'b1, fp[6:0]};
    for (int i = 0; i < 7; i++) begin
      if (y[i]) p = p ^ (14'(x) << i);
    end
    for (int i = 12; i >= 7; i--) begin
      if (p[i]) p = p ^ (fw << (i - 7));
    end
    return p[6:0];
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic start_op(input int g, input logic [6:0] x, input logic [6:0] y);
    dut_a[g]     = x;
    dut_b[g]     = y;
    dut_start[g] = 1'b1;
    @(negedge clk);
    dut_start[g] = 1'b0;
  endtask

  // k counts edges since acceptance; lat=-1 if over never shows within the bound.
  task automatic wait_done(input int g, output int lat, output int bc);
    lat = -1;
    bc  = 0;
    for (int k = 0; k <= 20; k++) begin
      if (k > 0) @(negedge clk);
      if (dut_over[g]) begin
        lat = k;
        break;
      end
      if (dut_busy[g]) bc++;
    end
  endtask

  task automatic run_op(input int g, input logic [6:0] x, input logic [6:0] y,
                        input logic [6:0] exp, input string tag);
    int lat, bc;
    start_op(g, x, y);
    wait_done(g, lat, bc);
    check({tag, " c"}, 32'(dut_c[g]), 32'(exp));
    check({tag, " latency"}, lat, nd(g));
    check({tag, " busy cycles"}, bc, nd(g));
    check({tag, " busy at over"}, 32'(dut_busy[g]), 0);
  endtask

  typedef struct {
    int         g;
    logic [6:0] a;
    logic [6:0] b;
    logic [6:0] exp;
  } vec_t;

  vec_t vt [8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, bc;
    logic [6:0] x, y;

    vt[0] = '{0, 7'h40, 7'h02, 7'h03};
    vt[1] = '{0, 7'h40, 7'h40, 7'h60};
    vt[2] = '{0, 7'h01, 7'h55, 7'h55};
    vt[3] = '{0, 7'h00, 7'h55, 7'h00};
    vt[4] = '{1, 7'h40, 7'h02, 7'h03};
    vt[5] = '{2, 7'h40, 7'h40, 7'h60};
    vt[6] = '{3, 7'h01, 7'h55, 7'h55};
    vt[7] = '{3, 7'h7F, 7'h00, 7'h00};

    rst     = 1'b1;
    fpoly   = 8'h83;
    acc_val = 7'h00;
    for (int g = 0; g < NI; g++) begin
      dut_start[g] = 1'b0;
      dut_a[g]     = '0;
      dut_b[g]     = '0;
    end
    repeat (3) @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      check("reset c", 32'(dut_c[g]), 0);
      check("reset busy", 32'(dut_busy[g]), 0);
      check("reset over", 32'(dut_over[g]), 0);
    end
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_op(vt[i].g, vt[i].a, vt[i].b, vt[i].exp, $sformatf("vec%0d", i));
      @(negedge clk);
    end

    // Back-to-back: second start issued in the over cycle of the first.
    start_op(0, 7'h40, 7'h40);
    wait_done(0, lat, bc);
    check("b2b first c", 32'(dut_c[0]), 32'h60);
    check("b2b first latency", lat, 4);
    dut_a[0]     = 7'h01;
    dut_b[0]     = 7'h55;
    dut_start[0] = 1'b1;
    @(negedge clk);
    dut_start[0] = 1'b0;
    check("b2b accepted busy", 32'(dut_busy[0]), 1);
    check("b2b c held", 32'(dut_c[0]), 32'h60);
    wait_done(0, lat, bc);
    check("b2b second latency", lat, 4);
    check("b2b second c", 32'(dut_c[0]), 32'h55);
    @(negedge clk);

    // Start while busy is ignored.
    start_op(0, 7'h40, 7'h02);
    repeat (2) @(negedge clk);
    dut_a[0]     = 7'h7F;
    dut_b[0]     = 7'h7F;
    dut_start[0] = 1'b1;
    @(negedge clk);
    dut_start[0] = 1'b0;
    wait_done(0, lat, bc);
    check("ignored start latency", lat, 1);
    check("ignored start c", 32'(dut_c[0]), 32'h03);
    @(negedge clk);
    check("ignored start not queued", 32'(dut_busy[0]), 0);
    check("c held in idle", 32'(dut_c[0]), 32'h03);

    // Reset in the middle of a run.
    start_op(0, 7'h40, 7'h40);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrun reset c", 32'(dut_c[0]), 0);
    check("midrun reset busy", 32'(dut_busy[0]), 0);
    check("midrun reset over", 32'(dut_over[0]), 0);
    rst = 1'b0;
    @(negedge clk);
    run_op(0, 7'h40, 7'h02, 7'h03, "after reset");

    for (int g = 1; g < NI; g++) begin
      for (int i = 0; i < 200; i++) begin
        x = 7'($urandom_range(127));
        y = 7'($urandom_range(127));
        run_op(g, x, y, ref_mul(x, y, fpoly), $sformatf("rand D%0d", g));
      end
    end

    // Programmable (and possibly nonsensical) field polynomials.
    for (int i = 0; i < 50; i++) begin
      x     = 7'($urandom_range(127));
      y     = 7'($urandom_range(127));
      fpoly = 8'($urandom_range(255));
      run_op(0, x, y, ref_mul(x, y, fpoly), "rand f");
    end
    fpoly = 8'h83;

`ifdef GF2M_MAC_EN
    acc_val = 7'h7F;
    run_op(0, 7'h40, 7'h02, 7'h7C, "mac directed");
    for (int i = 0; i < 50; i++) begin
      x       = 7'($urandom_range(127));
      y       = 7'($urandom_range(127));
      acc_val = 7'($urandom_range(127));
      run_op(2, x, y, ref_mul(x, y, fpoly) ^ acc_val, "mac rand");
    end
    acc_val = 7'h00;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
